// File: rtl/serial_subtractor.sv
// Bit-serial two's-complement subtractor.
// A single full-subtractor cell processes one bit per clock, LSB first, with the
// borrow carried between bits in a flip-flop. An operation occupies WIDTH RUN
// cycles followed by one DONE cycle, in which the registered results are presented
// alongside a one-cycle done strobe.
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow,
    output logic             ovf
);

    // Counter width is at least one bit so that WIDTH=1 still elaborates cleanly.
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state_reg;
    logic [WIDTH-1:0] a_sh_reg;
    logic [WIDTH-1:0] b_sh_reg;
    logic [WIDTH-1:0] res_reg;
    logic            bor_reg;
    logic [CW-1:0]   cnt_reg;

    logic            ai;
    logic            bi;
    logic            bin;
    logic            d;
    logic            bout;
    logic [WIDTH-1:0] res_next;

    // Full-subtractor cell on the current LSBs; the result bit enters from the MSB side.
    always_comb begin
        ai       = a_sh_reg[0];
        bi       = b_sh_reg[0];
        bin      = bor_reg;
        d        = ai ^ bi ^ bin;
        bout     = (~ai & bi) | (~(ai ^ bi) & bin);
        res_next = res_reg >> 1;
        res_next[WIDTH-1] = d;
    end

    // Control FSM and datapath. On the last RUN edge the final bit is folded straight
    // into the output registers, so the results and the strobe appear together in DONE.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
            a_sh_reg  <= '0;
            b_sh_reg  <= '0;
            res_reg   <= '0;
            bor_reg   <= 1'b0;
            cnt_reg   <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            diff      <= '0;
            borrow    <= 1'b0;
            ovf       <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        a_sh_reg  <= a;
                        b_sh_reg  <= b;
                        bor_reg   <= 1'b0;
                        cnt_reg   <= '0;
                        busy      <= 1'b1;
                        state_reg <= RUN;
                    end
                end
                RUN: begin
                    a_sh_reg <= a_sh_reg >> 1;
                    b_sh_reg <= b_sh_reg >> 1;
                    res_reg  <= res_next;
                    bor_reg  <= bout;
                    cnt_reg  <= cnt_reg + 1'b1;
                    if (cnt_reg == LAST) begin
                        // Signed overflow: borrow into the sign bit differs from borrow out of it.
                        diff      <= res_next;
                        borrow    <= bout;
                        ovf       <= bin ^ bout;
                        done      <= 1'b1;
                        busy      <= 1'b0;
                        state_reg <= DONE;
                    end
                end
                DONE: begin
                    state_reg <= IDLE;
                end
                default: begin
                    busy      <= 1'b0;
                    state_reg <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed and randomized checks for the bit-serial subtractor at WIDTH=8.
module tb_serial_subtractor;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic [W-1:0] diff;
    logic         borrow;
    logic         ovf;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    // Hand-computed vectors: a, b, expected diff, borrow, ovf
    logic [W-1:0] vec_a [0:6] = '{8'd5,  8'h80, 8'h7F, 8'hA5, 8'h00, 8'h00, 8'h01};
    logic [W-1:0] vec_b [0:6] = '{8'd10, 8'h01, 8'hFF, 8'hA5, 8'h00, 8'h01, 8'h80};
    logic [W-1:0] vec_d [0:6] = '{8'hFB, 8'h7F, 8'h80, 8'h00, 8'h00, 8'hFF, 8'h81};
    logic         vec_br[0:6] = '{1'b1,  1'b0,  1'b1,  1'b0,  1'b0,  1'b1,  1'b1};
    logic         vec_ov[0:6] = '{1'b0,  1'b1,  1'b1,  1'b0,  1'b0,  1'b0,  1'b1};

    serial_subtractor #(.WIDTH(W)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .a      (a),
        .b      (b),
        .busy   (busy),
        .done   (done),
        .diff   (diff),
        .borrow (borrow),
        .ovf    (ovf)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Pulse start for one edge; returns at the negedge of the first RUN cycle.
    task automatic start_op(input logic [W-1:0] xa, input logic [W-1:0] xb);
        @(negedge clk);
        a = xa;
        b = xb;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Advance at least one cycle, then wait (bounded) for the done strobe.
    task automatic wait_done(output int n, output bit timed_out);
        n = 0;
        @(negedge clk);
        n++;
        while (done !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        timed_out = (done !== 1'b1);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        start = 1'b0;
        a = '0;
        b = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", done); end
        checks++; if (diff !== 8'h00) begin errors++; $display("FAIL reset_diff: got %h want 00", diff); end
        checks++; if (borrow !== 1'b0) begin errors++; $display("FAIL reset_borrow: got %b want 0", borrow); end
        checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL reset_ovf: got %b want 0", ovf); end
        $display("reset: busy=%b done=%b diff=%h borrow=%b ovf=%b", busy, done, diff, borrow, ovf);
    endtask

    task automatic test_basic();
        int n;
        int bc;
        start_op(8'd200, 8'd55);
        n = 1;
        bc = 0;
        while (done !== 1'b1 && n < 40) begin
            if (busy === 1'b1) bc++;
            @(negedge clk);
            n++;
        end
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL basic_timeout: done=%b want 1", done); end
        checks++; if (n != W + 1) begin errors++; $display("FAIL basic_latency: got %0d want %0d", n, W + 1); end
        checks++; if (bc != W) begin errors++; $display("FAIL basic_busy_cycles: got %0d want %0d", bc, W); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL basic_busy_at_done: got %b want 0", busy); end
        checks++; if (diff !== 8'd145) begin errors++; $display("FAIL basic_diff: got %0d want 145", diff); end
        checks++; if (borrow !== 1'b0) begin errors++; $display("FAIL basic_borrow: got %b want 0", borrow); end
        checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL basic_ovf: got %b want 0", ovf); end
        $display("op 200-55: diff=%0d borrow=%b ovf=%b latency=%0d busy_cycles=%0d", diff, borrow, ovf, n, bc);
        @(negedge clk);
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL basic_done_pulse: got %b want 0", done); end
        checks++; if (diff !== 8'd145) begin errors++; $display("FAIL basic_diff_hold: got %0d want 145", diff); end
    endtask

    task automatic test_vectors();
        int n;
        bit to;
        for (int i = 0; i < 7; i++) begin
            start_op(vec_a[i], vec_b[i]);
            wait_done(n, to);
            checks++; if (to) begin errors++; $display("FAIL vec%0d_timeout: done=%b want 1", i, done); end
            checks++; if (diff !== vec_d[i]) begin errors++; $display("FAIL vec%0d_diff: got %h want %h", i, diff, vec_d[i]); end
            checks++; if (borrow !== vec_br[i]) begin errors++; $display("FAIL vec%0d_borrow: got %b want %b", i, borrow, vec_br[i]); end
            checks++; if (ovf !== vec_ov[i]) begin errors++; $display("FAIL vec%0d_ovf: got %b want %b", i, ovf, vec_ov[i]); end
            $display("op %h-%h: diff=%h borrow=%b ovf=%b", vec_a[i], vec_b[i], diff, borrow, ovf);
        end
    endtask

    task automatic test_ignore_start();
        int dcount;
        logic [W-1:0] dval;
        dcount = 0;
        dval = '0;
        start_op(8'd3, 8'd1);
        @(negedge clk);
        @(negedge clk);
        a = 8'd9;
        b = 8'd9;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        a = '0;
        b = '0;
        for (int i = 0; i < 30; i++) begin
            if (done === 1'b1) begin
                dcount++;
                dval = diff;
            end
            @(negedge clk);
        end
        checks++; if (dcount != 1) begin errors++; $display("FAIL ignore_done_count: got %0d want 1", dcount); end
        checks++; if (dval !== 8'd2) begin errors++; $display("FAIL ignore_diff: got %0d want 2", dval); end
        $display("op 3-1 with start during RUN: diff=%0d dones=%0d", dval, dcount);
    endtask

    task automatic test_reset_midrun();
        int dcount;
        int n;
        bit to;
        dcount = 0;
        start_op(8'd50, 8'd7);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midrst_busy: got %b want 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL midrst_done: got %b want 0", done); end
        checks++; if (diff !== 8'h00) begin errors++; $display("FAIL midrst_diff: got %h want 00", diff); end
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (done === 1'b1 || busy === 1'b1) dcount++;
        end
        checks++; if (dcount != 0) begin errors++; $display("FAIL midrst_quiet: got %0d active cycles want 0", dcount); end
        start_op(8'd10, 8'd4);
        wait_done(n, to);
        checks++; if (to) begin errors++; $display("FAIL midrst_new_timeout: done=%b want 1", done); end
        checks++; if (diff !== 8'd6) begin errors++; $display("FAIL midrst_new_diff: got %0d want 6", diff); end
        checks++; if (borrow !== 1'b0) begin errors++; $display("FAIL midrst_new_borrow: got %b want 0", borrow); end
        $display("reset mid-run then op 10-4: diff=%0d borrow=%b", diff, borrow);
    endtask

    task automatic test_back_to_back();
        int n;
        bit to;
        int prev;
        logic [W-1:0] ed;
        logic         eb;
        logic         eo;
        prev = 0;
        @(negedge clk);
        a = W'($urandom);
        b = W'($urandom);
        start = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            wait_done(n, to);
            checks++;
            if (to) begin
                errors++;
                $display("FAIL b2b_timeout: op %0d done=%b want 1", i, done);
                break;
            end
            ed = a - b;
            eb = (a < b);
            eo = (a[W-1] != b[W-1]) && (ed[W-1] != a[W-1]);
            checks++; if (diff !== ed) begin errors++; $display("FAIL b2b_diff: op %0d %h-%h got %h want %h", i, a, b, diff, ed); end
            checks++; if (borrow !== eb) begin errors++; $display("FAIL b2b_borrow: op %0d %h-%h got %b want %b", i, a, b, borrow, eb); end
            checks++; if (ovf !== eo) begin errors++; $display("FAIL b2b_ovf: op %0d %h-%h got %b want %b", i, a, b, ovf, eo); end
            if (i > 0) begin
                checks++;
                if (cyc - prev != W + 2) begin
                    errors++;
                    $display("FAIL b2b_interval: op %0d got %0d want %0d", i, cyc - prev, W + 2);
                end
            end
            prev = cyc;
            a = W'($urandom);
            b = W'($urandom);
        end
        start = 1'b0;
        repeat (15) @(negedge clk);
        $display("back-to-back: 1000 ops completed, last diff=%h", diff);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_vectors();
        test_ignore_start();
        test_reset_midrun();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
